// File: rtl/vc_mesh_rd_edge_pkg.sv
// Shared types and direction codes for the SRAM-mesh read edge endpoint.
// A returning beat carries the original command, so its direction can be checked.
package vc_mesh_rd_edge_pkg;

  localparam logic [1:0] VEC_CACHE_WEST  = 2'b00;
  localparam logic [1:0] VEC_CACHE_EAST  = 2'b01;
  localparam logic [1:0] VEC_CACHE_SOUTH = 2'b10;
  localparam logic [1:0] VEC_CACHE_NORTH = 2'b11;

  typedef struct packed {
    logic [1:0] direction_id;
    logic [5:0] tag;
  } txnid_t;

  typedef struct packed {
    txnid_t      txnid;
    logic [23:0] addr;
  } arb_out_req_t;

  typedef struct packed {
    arb_out_req_t cmd_pld;
    logic [31:0]  data;
  } data_pld_t;

  // Overwrites the direction field so the mesh routes the beat back to this edge.
  function automatic arb_out_req_t stamp_dir(input arb_out_req_t req, input logic [1:0] dir);
    arb_out_req_t res;
    res = req;
    res.txnid.direction_id = dir;
    return res;
  endfunction

endpackage

// File: rtl/vc_mesh_rd_edge_if.sv
// Request, mesh command, mesh data and response channels of one read edge.
// The edge uses the slave modport; the requestor/mesh side uses master.
interface vc_mesh_rd_edge_if;
  import vc_mesh_rd_edge_pkg::*;

  logic         req_vld;
  logic         req_rdy;
  arb_out_req_t req_pld;
  logic         mesh_cmd_vld;
  arb_out_req_t mesh_cmd_pld;
  logic         mesh_data_vld;
  data_pld_t    mesh_data_pld;
  logic         rsp_vld;
  logic         rsp_rdy;
  data_pld_t    rsp_pld;

  modport master (
    output req_vld, req_pld, mesh_data_vld, mesh_data_pld, rsp_rdy,
    input  req_rdy, mesh_cmd_vld, mesh_cmd_pld, rsp_vld, rsp_pld
  );

  modport slave (
    input  req_vld, req_pld, mesh_data_vld, mesh_data_pld, rsp_rdy,
    output req_rdy, mesh_cmd_vld, mesh_cmd_pld, rsp_vld, rsp_pld
  );
endinterface

// File: rtl/vc_edge_sync_fifo.sv
// Flop-based synchronous FIFO; head entry read straight out of the storage flops.
// A pop on a full FIFO frees the slot for a same-cycle write.
module vc_edge_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic             wr_fire_s;
  logic             rd_fire_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign rd_fire_s = rd_en & ~empty;
  assign wr_fire_s = wr_en & (~full | rd_fire_s);
  assign rd_data   = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer advance on each accepted write and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (wr_fire_s) wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
      if (rd_fire_s) rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
    end
  end

  // Storage write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
    end else if (wr_fire_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
    end
  end
endmodule

// File: rtl/vc_mesh_rd_edge.sv
// Read edge endpoint of the xy-switch SRAM mesh: credit-gated cmd injection,
// direction-filtered return buffering and a valid/ready response port.
module vc_mesh_rd_edge
  import vc_mesh_rd_edge_pkg::*;
#(
  parameter logic [1:0] DIR_ID = VEC_CACHE_WEST,
  parameter int         DEPTH  = 8,
  parameter int         CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vc_mesh_rd_edge_if.slave     bus,
  output logic                 idle,
  output logic                 err_overflow,
  output logic                 err_dir
);
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(DEPTH);

  logic [CNT_W-1:0]  credit_r;
  logic              mesh_cmd_vld_r;
  arb_out_req_t      mesh_cmd_pld_r;
  logic              err_overflow_r;
  logic              err_dir_r;
  logic              req_rdy_s;
  logic              issue_s;
  logic              pop_s;
  logic              dir_ok_s;
  logic              wr_en_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [$bits(data_pld_t)-1:0] rd_data_s;

  // Credits count free return slots: in-flight reads plus buffered beats consume one each.
  assign req_rdy_s = (credit_r != {CNT_W{1'b0}});
  assign issue_s   = bus.req_vld & req_rdy_s;
  assign pop_s     = ~fifo_empty_s & bus.rsp_rdy;
  assign dir_ok_s  = (bus.mesh_data_pld.cmd_pld.txnid.direction_id == DIR_ID);
  assign wr_en_s   = bus.mesh_data_vld & dir_ok_s;

  assign bus.req_rdy      = req_rdy_s;
  assign bus.mesh_cmd_vld = mesh_cmd_vld_r;
  assign bus.mesh_cmd_pld = mesh_cmd_pld_r;
  assign bus.rsp_vld      = ~fifo_empty_s;
  assign bus.rsp_pld      = data_pld_t'(rd_data_s);
  assign idle             = (credit_r == CREDIT_MAX);
  assign err_overflow     = err_overflow_r;
  assign err_dir          = err_dir_r;

  // Credit counter: issue takes a slot, pop returns one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_r <= CREDIT_MAX;
    end else begin
      case ({issue_s, pop_s})
        2'b10:   credit_r <= credit_r - CNT_W'(1);
        2'b01:   credit_r <= credit_r + CNT_W'(1);
        default: credit_r <= credit_r;
      endcase
    end
  end

  // One-cycle cmd pulse per accepted request, stamped with this edge's direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mesh_cmd_vld_r <= 1'b0;
      mesh_cmd_pld_r <= arb_out_req_t'({$bits(arb_out_req_t){1'b0}});
    end else begin
      mesh_cmd_vld_r <= issue_s;
      if (issue_s) mesh_cmd_pld_r <= stamp_dir(bus.req_pld, DIR_ID);
    end
  end

  // Sticky fault flags; a full buffer with a same-cycle pop still takes the beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overflow_r <= 1'b0;
      err_dir_r      <= 1'b0;
    end else begin
      if (wr_en_s & fifo_full_s & ~pop_s)   err_overflow_r <= 1'b1;
      if (bus.mesh_data_vld & ~dir_ok_s)    err_dir_r      <= 1'b1;
    end
  end

  vc_edge_sync_fifo #(
    .WIDTH ($bits(data_pld_t)),
    .DEPTH (DEPTH)
  ) u_ret_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en_s),
    .wr_data (bus.mesh_data_pld),
    .full    (fifo_full_s),
    .rd_en   (bus.rsp_rdy),
    .rd_data (rd_data_s),
    .empty   (fifo_empty_s)
  );
endmodule

// File: tb/tb_vc_mesh_rd_edge.sv
// Directed bench for vc_mesh_rd_edge with DEPTH=4 on a west edge.
// Expected values are hand-derived per scenario.
module tb_vc_mesh_rd_edge;
  import vc_mesh_rd_edge_pkg::*;

  logic clk;
  logic rst_n;
  logic idle;
  logic err_overflow;
  logic err_dir;
  int   total;
  int   bad;
  int   pulses;

  vc_mesh_rd_edge_if bus_if ();

  vc_mesh_rd_edge #(
    .DIR_ID (VEC_CACHE_WEST),
    .DEPTH  (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus_if),
    .idle         (idle),
    .err_overflow (err_overflow),
    .err_dir      (err_dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic arb_out_req_t mk_req(input logic [1:0] dir, input int tag);
    arb_out_req_t r;
    r.txnid.direction_id = dir;
    r.txnid.tag          = 6'(tag);
    r.addr               = 24'h00A000 + 24'(tag);
    return r;
  endfunction

  function automatic data_pld_t mk_beat(input logic [1:0] dir, input int tag);
    data_pld_t b;
    b.cmd_pld = mk_req(dir, tag);
    b.data    = 32'hD000_0000 + 32'(tag);
    return b;
  endfunction

  task automatic issue_n(input int n);
    bus_if.req_vld = 1'b1;
    for (int i = 0; i < n; i++) tick();
    bus_if.req_vld = 1'b0;
  endtask

  task automatic send_beat(input logic [1:0] dir, input int tag);
    bus_if.mesh_data_vld = 1'b1;
    bus_if.mesh_data_pld = mk_beat(dir, tag);
    tick();
    bus_if.mesh_data_vld = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus_if.req_vld       = 1'b0;
    bus_if.req_pld       = mk_req(VEC_CACHE_NORTH, 0);
    bus_if.mesh_data_vld = 1'b0;
    bus_if.mesh_data_pld = mk_beat(VEC_CACHE_WEST, 0);
    bus_if.rsp_rdy       = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // reset state
    check_val("rst_req_rdy", bus_if.req_rdy, 1);
    check_val("rst_idle", idle, 1);
    check_val("rst_cmd_vld", bus_if.mesh_cmd_vld, 0);
    check_val("rst_cmd_pld", bus_if.mesh_cmd_pld, 0);
    check_val("rst_rsp_vld", bus_if.rsp_vld, 0);
    check_val("rst_err_ovf", err_overflow, 0);
    check_val("rst_err_dir", err_dir, 0);

    // exhaust credits with req_vld held high
    pulses = 0;
    bus_if.req_vld = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_if.req_pld = mk_req(VEC_CACHE_NORTH, i);
      tick();
      pulses += int'(bus_if.mesh_cmd_vld);
      check_val("cmd_vld", bus_if.mesh_cmd_vld, (i < 4) ? 64'd1 : 64'd0);
      if (i < 4) check_val("cmd_pld", bus_if.mesh_cmd_pld, mk_req(VEC_CACHE_WEST, i));
    end
    bus_if.req_vld = 1'b0;
    check_val("cmd_pulses", 64'(pulses), 4);
    check_val("full_req_rdy", bus_if.req_rdy, 0);
    check_val("full_idle", idle, 0);

    // return 4 beats, then drain in order
    for (int i = 0; i < 4; i++) begin
      send_beat(VEC_CACHE_WEST, i);
      check_val("ret_rsp_vld", bus_if.rsp_vld, 1);
    end
    check_val("ret_req_rdy", bus_if.req_rdy, 0);
    bus_if.rsp_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_val("drain_vld", bus_if.rsp_vld, 1);
      check_val("drain_pld", bus_if.rsp_pld, mk_beat(VEC_CACHE_WEST, i));
      tick();
      check_val("drain_credit", 64'(dut.credit_r), 64'(i + 1));
      if (i == 0) check_val("drain_req_rdy", bus_if.req_rdy, 1);
    end
    bus_if.rsp_rdy = 1'b0;
    check_val("drain_idle", idle, 1);
    check_val("drain_empty", bus_if.rsp_vld, 0);

    // credit=1, issue and pop in the same cycle
    issue_n(3);
    check_val("c1_credit", 64'(dut.credit_r), 1);
    send_beat(VEC_CACHE_WEST, 10);
    check_val("c1_buf", bus_if.rsp_vld, 1);
    bus_if.req_vld = 1'b1;
    bus_if.rsp_rdy = 1'b1;
    tick();
    bus_if.req_vld = 1'b0;
    check_val("c1_same_credit", 64'(dut.credit_r), 1);
    check_val("c1_same_req_rdy", bus_if.req_rdy, 1);
    check_val("c1_same_cmd", bus_if.mesh_cmd_vld, 1);
    check_val("c1_same_rsp", bus_if.rsp_vld, 0);
    for (int i = 0; i < 3; i++) send_beat(VEC_CACHE_WEST, 11 + i);
    for (int i = 0; i < 3; i++) tick();
    bus_if.rsp_rdy = 1'b0;
    check_val("c1_idle", idle, 1);
    check_val("c1_credit_end", 64'(dut.credit_r), 4);

    // wrong-direction beat is dropped and flagged
    send_beat(VEC_CACHE_NORTH, 15);
    check_val("dir_err", err_dir, 1);
    check_val("dir_rsp", bus_if.rsp_vld, 0);
    for (int i = 0; i < 3; i++) tick();
    check_val("dir_sticky", err_dir, 1);
    check_val("dir_rsp_late", bus_if.rsp_vld, 0);
    check_val("dir_credit", 64'(dut.credit_r), 4);
    check_val("dir_no_ovf", err_overflow, 0);

    // 5 beats into a 4-deep buffer with no pop
    issue_n(4);
    for (int i = 0; i < 5; i++) begin
      send_beat(VEC_CACHE_WEST, 20 + i);
      check_val("ovf_flag", err_overflow, (i == 4) ? 64'd1 : 64'd0);
    end
    bus_if.rsp_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_val("ovf_pld", bus_if.rsp_pld, mk_beat(VEC_CACHE_WEST, 20 + i));
      tick();
    end
    bus_if.rsp_rdy = 1'b0;
    check_val("ovf_dropped", bus_if.rsp_vld, 0);
    check_val("ovf_idle", idle, 1);

    // reset with 2 cmds outstanding, 1 beat buffered and a cmd pulse live
    bus_if.req_vld = 1'b1;
    bus_if.req_pld = mk_req(VEC_CACHE_EAST, 40);
    tick();
    tick();
    bus_if.mesh_data_vld = 1'b1;
    bus_if.mesh_data_pld = mk_beat(VEC_CACHE_WEST, 40);
    tick();
    bus_if.req_vld       = 1'b0;
    bus_if.mesh_data_vld = 1'b0;
    check_val("pre_rst_cmd", bus_if.mesh_cmd_vld, 1);
    check_val("pre_rst_rsp", bus_if.rsp_vld, 1);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_val("mid_rst_credit", 64'(dut.credit_r), 4);
    check_val("mid_rst_idle", idle, 1);
    check_val("mid_rst_rsp", bus_if.rsp_vld, 0);
    check_val("mid_rst_cmd", bus_if.mesh_cmd_vld, 0);
    check_val("mid_rst_cmd_pld", bus_if.mesh_cmd_pld, 0);
    check_val("mid_rst_ovf", err_overflow, 0);
    check_val("mid_rst_dir", err_dir, 0);

    // full buffer with a pop during the 5th beat: beat accepted
    issue_n(4);
    for (int i = 0; i < 4; i++) send_beat(VEC_CACHE_WEST, 30 + i);
    bus_if.rsp_rdy = 1'b1;
    check_val("wp_head", bus_if.rsp_pld, mk_beat(VEC_CACHE_WEST, 30));
    send_beat(VEC_CACHE_WEST, 34);
    check_val("wp_no_ovf", err_overflow, 0);
    for (int i = 0; i < 4; i++) begin
      check_val("wp_pld", bus_if.rsp_pld, mk_beat(VEC_CACHE_WEST, 31 + i));
      tick();
    end
    bus_if.rsp_rdy = 1'b0;
    check_val("wp_empty", bus_if.rsp_vld, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
